butterfly_pipe: RTL and testbench

- Pipelined, handshaked successor of the combinational NTT butterfly, for the shared Kyber/Dilithium polynomial datapath.
- Per transaction it performs a Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT) butterfly, modulo q_Kyber=3329 or q_Dilithium=8380417.
- Mode bits and an ID tag travel with the data through a parametrised pipeline with valid/ready flow control.
- It sits between the coefficient memory read port and the write-back port of the NTT controller.

---
 rtl/butterfly_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
// Pipelined NTT butterfly for the shared Kyber/Dilithium polynomial datapath.
// Performs a Cooley-Tukey (forward) or Gentleman-Sande (inverse) butterfly with
// exact modular arithmetic, q = 3329 (Kyber) or q = 8380417 (Dilithium),
// selected per transaction. Mode bits and an ID tag ride along with the data.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   valid_i / ready_o       input handshake; ready_o = ready_i | ~valid_o
//   a_i, b_i, twiddle_i     operands, each < q
//   sel_red_i               1 = Kyber, 0 = Dilithium
//   sel_butterfly_i         0 = CT, 1 = GS
//   id_i / id_o             sideband tag, passed through unchanged
//   valid_o / ready_i       output handshake
//   a_out_o, b_out_o        results, fully reduced into [0,q)
//   busy_o                  any pipeline stage holds a valid transaction
//
// Pipeline: stage 0 registers inputs, stage 1 holds the twiddle product,
// stage 2 holds the reduced results, stages 3..LATENCY-1 are pure delay.

`default_nettype none

module butterfly_pipe #(
  parameter int DATA_W  = 23,
  parameter int LATENCY = 4,
  parameter int ID_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] twiddle_i,
  input  logic              sel_red_i,
  input  logic              sel_butterfly_i,
  input  logic [ID_W-1:0]   id_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] a_out_o,
  output logic [DATA_W-1:0] b_out_o,
  output logic [ID_W-1:0]   id_o,
  output logic              busy_o
);

  localparam int PW    = 2 * DATA_W;
  localparam int EXTRA = LATENCY - 3;

  function automatic logic [DATA_W-1:0] q_of(input logic kyber);
    return kyber ? DATA_W'(3329) : DATA_W'(8380417);
  endfunction

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + {1'b0, q} - {1'b0, y};
    return DATA_W'(d);
  endfunction

  // Reduction by one of two constants; each branch is a fixed-divisor modulo.
  function automatic logic [DATA_W-1:0] mod_red(input logic [PW-1:0] p,
                                                input logic kyber);
    return kyber ? DATA_W'(p % PW'(3329)) : DATA_W'(p % PW'(8380417));
  endfunction

  logic adv;
  logic busy_tail;

  assign adv     = ready_i | ~valid_o;
  assign ready_o = adv;

  // Stage 0: captured operands
  logic              v0_q;
  logic [DATA_W-1:0] a0_q, b0_q, w0_q;
  logic              kyb0_q, gs0_q;
  logic [ID_W-1:0]   id0_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_q   <= 1'b0;
      a0_q   <= '0;
      b0_q   <= '0;
      w0_q   <= '0;
      kyb0_q <= 1'b0;
      gs0_q  <= 1'b0;
      id0_q  <= '0;
    end else if (adv) begin
      v0_q <= valid_i;
      if (valid_i) begin
        a0_q   <= a_i;
        b0_q   <= b_i;
        w0_q   <= twiddle_i;
        kyb0_q <= sel_red_i;
        gs0_q  <= sel_butterfly_i;
        id0_q  <= id_i;
      end
    end
  end

  // Stage 1 inputs: CT multiplies b by w and keeps a; GS multiplies (a-b) by w
  // and already has its final a_out = a+b.
  logic [DATA_W-1:0] q0, mul_op_d, x1_d;
  logic [PW-1:0]     prod_d;

  always_comb begin
    q0       = q_of(kyb0_q);
    mul_op_d = gs0_q ? sub_mod(a0_q, b0_q, q0) : b0_q;
    x1_d     = gs0_q ? add_mod(a0_q, b0_q, q0) : a0_q;
    prod_d   = PW'(w0_q) * PW'(mul_op_d);
  end

  logic              v1_q;
  logic [DATA_W-1:0] x1_q;
  logic [PW-1:0]     prod1_q;
  logic              kyb1_q, gs1_q;
  logic [ID_W-1:0]   id1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      prod1_q <= '0;
      kyb1_q  <= 1'b0;
      gs1_q   <= 1'b0;
      id1_q   <= '0;
    end else if (adv) begin
      v1_q    <= v0_q;
      x1_q    <= x1_d;
      prod1_q <= prod_d;
      kyb1_q  <= kyb0_q;
      gs1_q   <= gs0_q;
      id1_q   <= id0_q;
    end
  end

  // Stage 2 inputs: reduce the product, then finish the CT add/sub.
  logic [DATA_W-1:0] q1, t_d, ao2_d, bo2_d;

  always_comb begin
    q1    = q_of(kyb1_q);
    t_d   = mod_red(prod1_q, kyb1_q);
    ao2_d = gs1_q ? x1_q : add_mod(x1_q, t_d, q1);
    bo2_d = gs1_q ? t_d  : sub_mod(x1_q, t_d, q1);
  end

  logic              v2_q;
  logic [DATA_W-1:0] ao2_q, bo2_q;
  logic [ID_W-1:0]   id2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v2_q  <= 1'b0;
      ao2_q <= '0;
      bo2_q <= '0;
      id2_q <= '0;
    end else if (adv) begin
      v2_q  <= v1_q;
      ao2_q <= ao2_d;
      bo2_q <= bo2_d;
      id2_q <= id1_q;
    end
  end

  generate
    if (EXTRA == 0) begin : g_direct
      assign valid_o   = v2_q;
      assign a_out_o   = ao2_q;
      assign b_out_o   = bo2_q;
      assign id_o      = id2_q;
      assign busy_tail = 1'b0;
    end else begin : g_delay
      logic [EXTRA-1:0]  dv_q;
      logic [DATA_W-1:0] dao_q [EXTRA];
      logic [DATA_W-1:0] dbo_q [EXTRA];
      logic [ID_W-1:0]   did_q [EXTRA];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          dv_q <= '0;
          for (int i = 0; i < EXTRA; i++) begin
            dao_q[i] <= '0;
            dbo_q[i] <= '0;
            did_q[i] <= '0;
          end
        end else if (adv) begin
          dv_q[0]  <= v2_q;
          dao_q[0] <= ao2_q;
          dbo_q[0] <= bo2_q;
          did_q[0] <= id2_q;
          for (int i = 1; i < EXTRA; i++) begin
            dv_q[i]  <= dv_q[i-1];
            dao_q[i] <= dao_q[i-1];
            dbo_q[i] <= dbo_q[i-1];
            did_q[i] <= did_q[i-1];
          end
        end
      end

      assign valid_o   = dv_q[EXTRA-1];
      assign a_out_o   = dao_q[EXTRA-1];
      assign b_out_o   = dbo_q[EXTRA-1];
      assign id_o      = did_q[EXTRA-1];
      assign busy_tail = |dv_q;
    end
  endgenerate

  assign busy_o = v0_q | v1_q | v2_q | busy_tail;

`ifndef SYNTHESIS
  logic [DATA_W-1:0] q_in;
  assign q_in = q_of(sel_red_i);

  a_operands_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i |-> (a_i < q_in && b_i < q_in && twiddle_i < q_in));
`endif

endmodule

`default_nettype wire

// File: tb/tb_butterfly_pipe.sv
`timescale 1ns/1ps

module tb_butterfly_pipe;
  parameter int LATENCY = 4;
  localparam int DW  = 23;
  localparam int IW  = 8;
  localparam longint QK = 3329;
  localparam longint QD = 8380417;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] a_i = '0, b_i = '0, twiddle_i = '0;
  logic          sel_red_i = 1'b0, sel_butterfly_i = 1'b0;
  logic [IW-1:0] id_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [DW-1:0] a_out_o, b_out_o;
  logic [IW-1:0] id_o;
  logic          busy_o;

  butterfly_pipe #(.DATA_W(DW), .LATENCY(LATENCY), .ID_W(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .twiddle_i(twiddle_i), .sel_red_i(sel_red_i),
    .sel_butterfly_i(sel_butterfly_i), .id_i(id_i), .valid_o(valid_o),
    .ready_i(ready_i), .a_out_o(a_out_o), .b_out_o(b_out_o), .id_o(id_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int out_cnt = 0;
  bit strict_lat = 1'b0;

  typedef struct {
    longint ea;
    longint eb;
    logic [IW-1:0] id;
    longint q;
    int acc;
  } exp_t;
  exp_t sb[$];

  // Reference: plain modular arithmetic straight from the butterfly definitions.
  function automatic void model(input longint a, input longint b, input longint w,
                                input bit kyber, input bit gs,
                                output longint ao, output longint bo);
    longint q, t;
    q = kyber ? QK : QD;
    if (!gs) begin
      t  = (w * b) % q;
      ao = (a + t) % q;
      bo = (a - t + q) % q;
    end else begin
      ao = (a + b) % q;
      bo = ((((a - b) % q) + q) % q * w) % q;
    end
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Compare process: every cycle the outputs are meaningful.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_a, prev_b;
  logic [IW-1:0] prev_id;

  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("ready_rule", ready_o, ready_i || !valid_o);
      check("busy", busy_o, sb.size() != 0);
      if (prev_stall) begin
        check("stall_valid", valid_o, 1);
        check("stall_a", a_out_o, prev_a);
        check("stall_b", b_out_o, prev_b);
        check("stall_id", id_o, prev_id);
      end
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_output", valid_o, 0);
        end else begin
          check("mon_a", a_out_o, sb[0].ea);
          check("mon_b", b_out_o, sb[0].eb);
          check("mon_id", id_o, sb[0].id);
          check("range", (a_out_o < sb[0].q) && (b_out_o < sb[0].q), 1);
          if (strict_lat) check("latency", cyc - sb[0].acc, LATENCY);
          else if (cyc - sb[0].acc < LATENCY) check("min_latency", cyc - sb[0].acc, LATENCY);
          if (ready_i) begin
            void'(sb.pop_front());
            out_cnt++;
          end
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_a = a_out_o; prev_b = b_out_o; prev_id = id_o;
      if (valid_i && ready_o) begin
        exp_t e;
        longint ao, bo;
        model(a_i, b_i, twiddle_i, sel_red_i, sel_butterfly_i, ao, bo);
        e.ea = ao; e.eb = bo; e.id = id_i;
        e.q = sel_red_i ? QK : QD; e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input longint a, input longint b, input longint w,
                      input bit kyber, input bit gs, input logic [IW-1:0] id);
    bit acc;
    acc = 1'b0;
    valid_i = 1'b1;
    a_i = DW'(a); b_i = DW'(b); twiddle_i = DW'(w);
    sel_red_i = kyber; sel_butterfly_i = gs; id_i = id;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (ready_o) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  // Ends on a falling edge where valid_o is high (or after the bound expires).
  task automatic wait_out();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (valid_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("output_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !valid_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk_i); #1;
  endtask

  task automatic rand_send(input logic [IW-1:0] id);
    bit k, g;
    longint q;
    k = 1'($urandom_range(1));
    g = 1'($urandom_range(1));
    q = k ? QK : QD;
    send($urandom_range(32'(q - 1)), $urandom_range(32'(q - 1)),
         $urandom_range(32'(q - 1)), k, g, id);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    longint ma, mb;
    int start_cnt;
    bit sender_done;

    // Pin the reference model to hand-computed values.
    model(3210, 19, 281, 1, 0, ma, mb);
    check("model_kct_a", ma, 1891); check("model_kct_b", mb, 1200);
    model(8297430, 7194, 400232, 0, 0, ma, mb);
    check("model_dct_a", ma, 4702990); check("model_dct_b", mb, 3511453);

    // Reset state
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid_o", valid_o, 0); check("rst_busy", busy_o, 0);
    check("rst_a", a_out_o, 0); check("rst_b", b_out_o, 0); check("rst_id", id_o, 0);
    rst_i = 1'b0;
    #1 check("rst_ready_o", ready_o, 1);
    @(posedge clk_i); #1;

    strict_lat = 1'b1;

    // Kyber CT
    send(3210, 19, 281, 1, 0, 8'h11); idle();
    wait_out();
    check("kct_a", a_out_o, 1891); check("kct_b", b_out_o, 1200); check("kct_id", id_o, 8'h11);
    @(posedge clk_i); #1;

    // Kyber GS followed back to back by Dilithium CT
    send(1891, 1200, 281, 1, 1, 8'h22);
    send(8297430, 7194, 400232, 0, 0, 8'h33); idle();
    wait_out();
    check("kgs_a", a_out_o, 3091); check("kgs_b", b_out_o, 1089); check("kgs_id", id_o, 8'h22);
    @(negedge clk_i);
    check("dct_valid", valid_o, 1);
    check("dct_a", a_out_o, 4702990); check("dct_b", b_out_o, 3511453); check("dct_id", id_o, 8'h33);
    @(posedge clk_i); #1;

    // Wrap boundaries
    send(0, 1, 1, 1, 0, 8'h44); idle();
    wait_out();
    check("wrap_kct_a", a_out_o, 1); check("wrap_kct_b", b_out_o, 3328);
    @(posedge clk_i); #1;
    send(0, 1, 1, 0, 1, 8'h55); idle();
    wait_out();
    check("wrap_dgs_a", a_out_o, 1); check("wrap_dgs_b", b_out_o, 8380416);
    drain();

    // Backpressure: 10 transactions, ready_i low for 5 cycles mid-stream
    strict_lat = 1'b0;
    start_cnt = out_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) rand_send(8'(8'h60 + i));
        idle();
      end
      begin
        repeat (6) @(posedge clk_i);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("bp_valid_o", valid_o, 1);
        check("bp_ready_o_low", ready_o, 0);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("bp_count", out_cnt - start_cnt, 10);

    // Reset with three transactions in flight
    strict_lat = 1'b1;
    start_cnt = out_cnt;
    send(100, 200, 300, 1, 0, 8'hA1);
    send(1000, 2000, 3000, 0, 1, 8'hA2);
    send(5, 6, 7, 1, 1, 8'hA3);
    idle();
    ready_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("mrst_valid_o", valid_o, 0); check("mrst_busy", busy_o, 0);
    check("mrst_a", a_out_o, 0); check("mrst_b", b_out_o, 0); check("mrst_id", id_o, 0);
    rst_i = 1'b0; ready_i = 1'b1;
    #1 check("mrst_ready_o", ready_o, 1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      check("mrst_no_output", valid_o, 0);
    end
    check("mrst_dropped", out_cnt - start_cnt, 0);
    @(posedge clk_i); #1;
    send(3210, 19, 281, 1, 0, 8'hB0); idle();
    wait_out();
    check("post_rst_a", a_out_o, 1891); check("post_rst_b", b_out_o, 1200);
    check("post_rst_id", id_o, 8'hB0);
    drain();

    // Random regression with random ready_i
    strict_lat = 1'b0;
    start_cnt = out_cnt;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            idle();
            @(posedge clk_i); #1;
          end
          rand_send(8'(i));
        end
        idle();
        sender_done = 1'b1;
      end
      begin
        while (!sender_done) begin
          @(posedge clk_i); #1;
          ready_i = ($urandom_range(3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();
    check("rand_count", out_cnt - start_cnt, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
